// File: rtl/host_cmd_master.sv
// Host command master: serialises register/ALU commands into byte frames and collects a one-byte response.
// Optional feature macro: RSP_TIMEOUT_EN adds a TIMEOUT_CYCLES response watchdog.
module host_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_ADDR        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [1:0]            REQ_OPCODE,
    input  logic [RF_ADDR-1:0]    REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA_A,
    input  logic [DATA_WIDTH-1:0] REQ_DATA_B,
    input  logic [3:0]            REQ_FUN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    input  logic                  TX_BUSY,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_DATA_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_VALID,
    output logic                  RSP_TIMEOUT,
    output logic                  CMD_DONE
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                state_r;
    logic [1:0]            idx_r;
    logic [1:0]            op_r;
    logic [RF_ADDR-1:0]    addr_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [3:0]            fun_r;
    logic [DATA_WIDTH-1:0] tx_data_r;
    logic                  tx_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  rsp_valid_r;
    logic                  cmd_done_r;
`ifdef RSP_TIMEOUT_EN
    logic                  rsp_timeout_r;
    logic [15:0]           tmo_cnt_r;
`endif

    // Byte at position idx of the frame for opcode op.
    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input logic [1:0]            op,
        input logic [1:0]            idx,
        input logic [RF_ADDR-1:0]    addr,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [3:0]            fun
    );
        logic [DATA_WIDTH-1:0] byte_s;
        byte_s = '0;
        case (op)
            2'b00: begin
                case (idx)
                    2'd0:    byte_s = DATA_WIDTH'(8'hAA);
                    2'd1:    byte_s = DATA_WIDTH'(addr);
                    2'd2:    byte_s = a;
                    default: byte_s = '0;
                endcase
            end
            2'b01: begin
                case (idx)
                    2'd0:    byte_s = DATA_WIDTH'(8'hBB);
                    2'd1:    byte_s = DATA_WIDTH'(addr);
                    default: byte_s = '0;
                endcase
            end
            2'b10: begin
                case (idx)
                    2'd0:    byte_s = DATA_WIDTH'(8'hCC);
                    2'd1:    byte_s = a;
                    2'd2:    byte_s = b;
                    default: byte_s = DATA_WIDTH'(fun);
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    byte_s = DATA_WIDTH'(8'hDD);
                    2'd1:    byte_s = DATA_WIDTH'(fun);
                    default: byte_s = '0;
                endcase
            end
        endcase
        return byte_s;
    endfunction

    // Index of the final byte of each frame type.
    function automatic logic [1:0] last_idx(input logic [1:0] op);
        case (op)
            2'b00:   return 2'd2;
            2'b01:   return 2'd1;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    assign REQ_READY     = (state_r == IDLE) && !RST;
    assign TX_P_DATA     = tx_data_r;
    assign TX_DATA_VALID = tx_valid_r;
    assign RSP_DATA      = rsp_data_r;
    assign RSP_VALID     = rsp_valid_r;
    assign CMD_DONE      = cmd_done_r;
`ifdef RSP_TIMEOUT_EN
    assign RSP_TIMEOUT   = rsp_timeout_r;
`else
    assign RSP_TIMEOUT   = 1'b0;
`endif

    // Command FSM with registered frame and response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            op_r          <= 2'b00;
            addr_r        <= '0;
            a_r           <= '0;
            b_r           <= '0;
            fun_r         <= 4'd0;
            tx_data_r     <= '0;
            tx_valid_r    <= 1'b0;
            rsp_data_r    <= '0;
            rsp_valid_r   <= 1'b0;
            cmd_done_r    <= 1'b0;
`ifdef RSP_TIMEOUT_EN
            rsp_timeout_r <= 1'b0;
            tmo_cnt_r     <= 16'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        op_r       <= REQ_OPCODE;
                        addr_r     <= REQ_ADDR;
                        a_r        <= REQ_DATA_A;
                        b_r        <= REQ_DATA_B;
                        fun_r      <= REQ_FUN;
                        idx_r      <= 2'd0;
                        tx_data_r  <= frame_byte(REQ_OPCODE, 2'd0, REQ_ADDR, REQ_DATA_A, REQ_DATA_B, REQ_FUN);
                        tx_valid_r <= 1'b1;
                        state_r    <= SEND;
                    end
                end
                SEND: begin
                    if (!TX_BUSY) begin
                        if (idx_r == last_idx(op_r)) begin
                            tx_valid_r <= 1'b0;
                            tx_data_r  <= '0;
                            if (op_r == 2'b00) begin
                                cmd_done_r <= 1'b1;
                                state_r    <= DONE;
                            end else begin
`ifdef RSP_TIMEOUT_EN
                                tmo_cnt_r  <= 16'd0;
`endif
                                state_r    <= WAIT_RSP;
                            end
                        end else begin
                            idx_r     <= idx_r + 2'd1;
                            tx_data_r <= frame_byte(op_r, idx_r + 2'd1, addr_r, a_r, b_r, fun_r);
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the expiry cycle still wins.
                    if (RX_DATA_VALID) begin
                        rsp_data_r  <= RX_P_DATA;
                        rsp_valid_r <= 1'b1;
                        cmd_done_r  <= 1'b1;
                        state_r     <= DONE;
                    end
`ifdef RSP_TIMEOUT_EN
                    else if (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_r    <= '0;
                        rsp_timeout_r <= 1'b1;
                        cmd_done_r    <= 1'b1;
                        state_r       <= DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
`endif
                end
                DONE: begin
                    rsp_valid_r   <= 1'b0;
                    cmd_done_r    <= 1'b0;
`ifdef RSP_TIMEOUT_EN
                    rsp_timeout_r <= 1'b0;
`endif
                    state_r       <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of every frame byte, request data and response data.
REQ-002 The block SHALL have parameter RF_ADDR, default 4: register-file address width, zero-extended to DATA_WIDTH on the wire.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50000: response wait limit in clock cycles, with a 16-bit counter.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: CLK input 1 is the clock, and RST input 1 is the reset, sampled only on the rising edge of CLK.
REQ-005 REQ_VALID  input  1  command request present.
REQ-006 REQ_READY  output  1  command can be accepted.
REQ-007 REQ_OPCODE  input  2  command type: 00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-008 REQ_ADDR  input  RF_ADDR  register address.
REQ-009 REQ_DATA_A  input  DATA_WIDTH  write data or operand A.
REQ-010 REQ_DATA_B  input  DATA_WIDTH  operand B.
REQ-011 REQ_FUN  input  4  ALU function code, zero-extended on the wire.
REQ-012 TX_P_DATA  output  DATA_WIDTH  byte to the serial transmitter.
REQ-013 TX_DATA_VALID  output  1  TX_P_DATA valid.
REQ-014 TX_BUSY  input  1  transmitter cannot take a byte.
REQ-015 RX_P_DATA  input  DATA_WIDTH  byte from the serial receiver.
REQ-016 RX_DATA_VALID  input  1  RX_P_DATA valid for one cycle.
REQ-017 RSP_DATA  output  DATA_WIDTH  response byte.
REQ-018 RSP_VALID  output  1  one-cycle pulse: RSP_DATA valid.
REQ-019 RSP_TIMEOUT  output  1  one-cycle pulse: response did not arrive in time.
REQ-020 CMD_DONE  output  1  one-cycle pulse: command finished (including timeout).

Function
REQ-021 REQ_READY SHALL be 1 only in IDLE with RST=0; a request SHALL be captured into internal registers on a cycle with REQ_VALID=1 and REQ_READY=1.
REQ-022 The frames SHALL be, in order:
- write: AA, addr, A
- read: BB, addr
- ALU with operands: CC, A, B, fun
- ALU without operands: DD, fun
REQ-023 The states SHALL be IDLE, SEND, WAIT_RSP and DONE.
- IDLE->SEND on capture.
- SEND->DONE after the last byte of a write.
- SEND->WAIT_RSP after the last byte of any other frame.
- WAIT_RSP->DONE on response or timeout.
- DONE->IDLE unconditionally.
REQ-024 In SEND, TX_DATA_VALID SHALL be 1 with TX_P_DATA holding the current byte; a byte is consumed on each cycle with TX_DATA_VALID=1 and TX_BUSY=0, and the byte index SHALL then advance.
REQ-025 TX_DATA_VALID SHALL first assert in the cycle after capture, and TX_P_DATA SHALL stay stable while TX_BUSY=1.
REQ-026 In WAIT_RSP, the first RX_DATA_VALID=1 SHALL load RSP_DATA=RX_P_DATA and pulse RSP_VALID in the DONE cycle.
REQ-027 RX_DATA_VALID SHALL be ignored in every state other than WAIT_RSP.
REQ-028 CMD_DONE SHALL pulse for exactly one cycle in DONE for every accepted command.
REQ-029 A write SHALL produce no RSP_VALID.
REQ-030 REQ_VALID held high through DONE SHALL be accepted in the IDLE cycle that follows, never earlier.
REQ-031 RSP_DATA SHALL hold its value until the next response or timeout.

Reset
REQ-032 RST=1 at a clock edge SHALL force state IDLE, clear the byte index and timeout counter, and abort any frame in progress without completing it.
REQ-033 RST=1 at a clock edge SHALL set RSP_DATA=0, and TX_DATA_VALID, RSP_VALID, RSP_TIMEOUT, CMD_DONE and TX_P_DATA to 0.
REQ-034 REQ_READY SHALL be 0 while RST=1, and 1 from the first cycle after RST deasserts.

Configuration
REQ-035 With macro RSP_TIMEOUT_EN defined, WAIT_RSP SHALL count cycles from entry; on the TIMEOUT_CYCLES-th cycle with no RX_DATA_VALID it SHALL go to DONE, pulse RSP_TIMEOUT and set RSP_DATA=0.
REQ-036 With RSP_TIMEOUT_EN defined, RX_DATA_VALID SHALL take priority over an expiring counter in the same cycle.
REQ-037 Without RSP_TIMEOUT_EN, there SHALL be no counter, WAIT_RSP SHALL wait indefinitely, and RSP_TIMEOUT SHALL be tied 0.

Verification
REQ-038 Write: opcode 00, addr 5, A=3C, TX_BUSY=0 -> bytes AA,05,3C on consecutive cycles; CMD_DONE pulse; no RSP_VALID.
REQ-039 Read: opcode 01, addr 2, RX byte 7E after 10 cycles -> bytes BB,02; RSP_DATA=7E; RSP_VALID and CMD_DONE pulse together.
REQ-040 ALU: opcode 10, A=12, B=34, fun 1, TX_BUSY=1 for 5 cycles per byte -> CC,12,34,01 each held stable, each consumed once; RX 46 -> RSP_DATA=46.
REQ-041 Timeout (RSP_TIMEOUT_EN, TIMEOUT_CYCLES=20): opcode 11, fun 3, no RX -> DD,03; RSP_TIMEOUT pulse 20 cycles after WAIT_RSP entry; RSP_DATA=00.
REQ-042 RST=1 while the second byte of a read is pending -> no further TX_DATA_VALID; REQ_READY=1 after release; a new write completes normally.
REQ-043 Stray RX byte 55 in IDLE, then a read answered with 9A -> RSP_DATA=9A, not 55.
